// File: rtl/cla_shared_add_ctrl.sv
// ---------------------------------------------------------------------------
// cla_shared_add_ctrl
//
// Shares one 4-bit augmented carry-lookahead slice between two requesters to
// perform W-bit additions (W = 4*NIBBLES), one nibble per clock, LSB first.
// A round-robin arbiter picks a requester and latches its operands. The slice
// then steps through the nibbles with a registered inter-nibble carry. The
// result is sum, carry-out, group propagate/generate and signed overflow,
// qualified by a one-cycle done pulse.
//
// Ports (CLA_4_bit_augmented):
//   a_i, b_i       4-bit operand nibbles
//   cin_i          carry into the nibble
//   sum_o          nibble sum
//   cout_o         carry out of the nibble
//   p_o, g_o       nibble group propagate / generate
//
// Ports (cla_shared_add_ctrl):
//   clk            clock, rising edge
//   rst            synchronous active-high reset
//   req0_i/req1_i  request levels, held until the matching done pulse
//   a0_i,b0_i      requester 0 operands;  cin0_i carry-in
//   a1_i,b1_i      requester 1 operands;  cin1_i carry-in
//   busy_o         high from grant until the end of the done cycle
//   grantId_o      requester currently or last served
//   done_o         one-cycle pulse, result valid
//   doneId_o       requester the result belongs to
//   sum_o          W-bit sum
//   cout_o         carry out of the MSB nibble
//   p_o, g_o       group propagate / generate over all W bits
//   ovf_o          two's-complement overflow
// ---------------------------------------------------------------------------

// Purely combinational 4-bit lookahead slice with group P/G outputs.
module CLA_4_bit_augmented (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o,
    output logic       p_o,
    output logic       g_o
);

    logic [3:0] prop;
    logic [3:0] gen;
    logic [3:0] carry;

    // Every internal carry is expanded directly from the nibble's generate and
    // propagate terms, so no carry has to ripple through the bits below it.
    always_comb begin
        prop     = a_i ^ b_i;
        gen      = a_i & b_i;
        carry[0] = cin_i;
        carry[1] = gen[0] | (prop[0] & cin_i);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin_i);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin_i);
        p_o      = &prop;
        g_o      = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);
        cout_o   = g_o | (p_o & cin_i);
        sum_o    = prop ^ carry;
    end

endmodule

module cla_shared_add_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_i,
    input  logic         req1_i,
    input  logic [W-1:0] a0_i,
    input  logic [W-1:0] b0_i,
    input  logic         cin0_i,
    input  logic [W-1:0] a1_i,
    input  logic [W-1:0] b1_i,
    input  logic         cin1_i,
    output logic         busy_o,
    output logic         grantId_o,
    output logic         done_o,
    output logic         doneId_o,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         p_o,
    output logic         g_o,
    output logic         ovf_o
);

    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    aReg_q;
    logic [W-1:0]    bReg_q;
    logic [W-1:0]    sumReg_q;
    logic            carry_q;
    logic            pAcc_q;
    logic            gAcc_q;
    logic            lastGnt_q;

    logic            busy_q;
    logic            grantId_q;
    logic            done_q;
    logic            doneId_q;
    logic [W-1:0]    sum_q;
    logic            cout_q;
    logic            p_q;
    logic            g_q;
    logic            ovf_q;

    logic [3:0]      sliceA;
    logic [3:0]      sliceB;
    logic [3:0]      sliceSum;
    logic            sliceCout;
    logic            sliceP;
    logic            sliceG;

    logic [W-1:0]    sumNext_d;
    logic            pAcc_d;
    logic            gAcc_d;
    logic            ovf_d;
    logic            winner_d;

    // The current nibble of each latched operand feeds the shared slice. The
    // carry comes from the previous nibble's registered carry-out.
    assign sliceA = aReg_q[{idx_q, 2'b00} +: 4];
    assign sliceB = bReg_q[{idx_q, 2'b00} +: 4];

    CLA_4_bit_augmented uSlice (
        .a_i    (sliceA),
        .b_i    (sliceB),
        .cin_i  (carry_q),
        .sum_o  (sliceSum),
        .cout_o (sliceCout),
        .p_o    (sliceP),
        .g_o    (sliceG)
    );

    // This block computes the next accumulated word state after the current
    // nibble. Group P/G combine like a lookahead tree folded over time: the
    // new nibble is the more significant one, so its generate dominates.
    // Overflow is computed from the final word when the last nibble lands.
    // On a tie, the arbiter grants the requester that was not served last.
    always_comb begin
        sumNext_d = sumReg_q;
        sumNext_d[{idx_q, 2'b00} +: 4] = sliceSum;
        pAcc_d   = pAcc_q & sliceP;
        gAcc_d   = sliceG | (sliceP & gAcc_q);
        ovf_d    = (aReg_q[W-1] == bReg_q[W-1]) && (sumNext_d[W-1] != aReg_q[W-1]);
        winner_d = (req0_i && req1_i) ? ~lastGnt_q : req1_i;
    end

    // Controller FSM with registered outputs. Reset also clears the visible
    // results, so an operation that is aborted leaves nothing stale behind.
    // No done pulse occurs for that operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            aReg_q    <= '0;
            bReg_q    <= '0;
            sumReg_q  <= '0;
            carry_q   <= 1'b0;
            pAcc_q    <= 1'b0;
            gAcc_q    <= 1'b0;
            lastGnt_q <= 1'b1;
            busy_q    <= 1'b0;
            grantId_q <= 1'b0;
            done_q    <= 1'b0;
            doneId_q  <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            p_q       <= 1'b0;
            g_q       <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req0_i || req1_i) begin
                        aReg_q    <= winner_d ? a1_i : a0_i;
                        bReg_q    <= winner_d ? b1_i : b0_i;
                        carry_q   <= winner_d ? cin1_i : cin0_i;
                        idx_q     <= '0;
                        pAcc_q    <= 1'b1;
                        gAcc_q    <= 1'b0;
                        grantId_q <= winner_d;
                        lastGnt_q <= winner_d;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    sumReg_q <= sumNext_d;
                    carry_q  <= sliceCout;
                    pAcc_q   <= pAcc_d;
                    gAcc_q   <= gAcc_d;
                    idx_q    <= idx_q + IDXW'(1);
                    if (idx_q == LAST_IDX) begin
                        sum_q    <= sumNext_d;
                        cout_q   <= sliceCout;
                        p_q      <= pAcc_d;
                        g_q      <= gAcc_d;
                        ovf_q    <= ovf_d;
                        done_q   <= 1'b1;
                        doneId_q <= grantId_q;
                        idx_q    <= '0;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = busy_q;
    assign grantId_o = grantId_q;
    assign done_o    = done_q;
    assign doneId_o  = doneId_q;
    assign sum_o     = sum_q;
    assign cout_o    = cout_q;
    assign p_o       = p_q;
    assign g_o       = g_q;
    assign ovf_o     = ovf_q;

endmodule
